// File: rtl/if_id_stage_pkg.sv
// Shared decode constants for the IF/ID stage: opcodes, NOP word, field positions.
package if_id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;

    // True when the instruction sources Rt as an operand (R-type, branches, stores).
    function automatic logic reads_rt(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: reads_rt = 1'b1;
            default:                                      reads_rt = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// IF/ID stage bus: fetch inputs, hazard inputs, held instruction and decode fields.
interface if_id_stage_if #(parameter int CNT_WIDTH = 16);

    logic [31:0]          Instr_in;
    logic [31:0]          PCPlus4_in;
    logic                 Flush;
    logic                 Hold;
    logic                 IDEX_MemRead;
    logic [4:0]           IDEX_Rt;

    logic [31:0]          Instr_out;
    logic [31:0]          PCPlus4_out;
    logic                 Valid_out;
    logic [5:0]           Opcode;
    logic [4:0]           Rs;
    logic [4:0]           Rt;
    logic [4:0]           Rd;
    logic [4:0]           Shamt;
    logic [5:0]           Funct;
    logic [15:0]          Imm16;
    logic                 Stall;
    logic [CNT_WIDTH-1:0] StallCount;

    modport master (
        output Instr_in, PCPlus4_in, Flush, Hold, IDEX_MemRead, IDEX_Rt,
        input  Instr_out, PCPlus4_out, Valid_out, Opcode, Rs, Rt, Rd, Shamt,
               Funct, Imm16, Stall, StallCount
    );

    modport slave (
        input  Instr_in, PCPlus4_in, Flush, Hold, IDEX_MemRead, IDEX_Rt,
        output Instr_out, PCPlus4_out, Valid_out, Opcode, Rs, Rt, Rd, Shamt,
               Funct, Imm16, Stall, StallCount
    );

endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detection: stall when the load in EX writes a register the
// held instruction reads. Purely combinational; the bubble clears it next cycle.
module hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic       valid,
    input  logic [5:0] opcode,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       stall
);

    logic rs_hit;
    logic rt_hit;

    // $0 is never a real dependency, so a zero load destination never stalls.
    always_comb begin
        rs_hit = (idex_rt == rs);
        rt_hit = reads_rt(opcode) && (idex_rt == rt);
        stall  = valid && idex_memread && (idex_rt != 5'd0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with decode field split, load-use stall and a
// saturating stall-cycle counter.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF,
    parameter int          CNT_WIDTH = 16
) (
    input logic         Clk,
    input logic         Reset,
    if_id_stage_if.slave bus
);

    logic [31:0]          instr_q;
    logic [31:0]          pc4_q;
    logic                 valid_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 stall;
    logic                 freeze;

    assign freeze = stall | bus.Hold;

    hazard_detect u_hazard (
        .valid        (valid_q),
        .opcode       (instr_q[OPC_LSB +: 6]),
        .rs           (instr_q[RS_LSB  +: 5]),
        .rt           (instr_q[RT_LSB  +: 5]),
        .idex_memread (bus.IDEX_MemRead),
        .idex_rt      (bus.IDEX_Rt),
        .stall        (stall)
    );

    // Pipeline register: Flush beats a freeze so a squashed slot never lingers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (bus.Flush) begin
            instr_q <= NOP_WORD;
            pc4_q   <= bus.PCPlus4_in;
            valid_q <= 1'b0;
        end else if (!freeze) begin
            instr_q <= bus.Instr_in;
            pc4_q   <= bus.PCPlus4_in;
            valid_q <= 1'b1;
        end
    end

    // Stall-cycle counter, sticks at all-ones; flush-coincident stalls still count.
    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_q <= '0;
        else if (freeze && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.Instr_out   = instr_q;
    assign bus.PCPlus4_out = pc4_q;
    assign bus.Valid_out   = valid_q;
    assign bus.Opcode      = instr_q[OPC_LSB +: 6];
    assign bus.Rs          = instr_q[RS_LSB  +: 5];
    assign bus.Rt          = instr_q[RT_LSB  +: 5];
    assign bus.Rd          = instr_q[RD_LSB  +: 5];
    assign bus.Shamt       = instr_q[SH_LSB  +: 5];
    assign bus.Funct       = instr_q[FN_LSB  +: 6];
    assign bus.Imm16       = instr_q[15:0];
    assign bus.Stall       = stall;
    assign bus.StallCount  = cnt_q;

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register with integrated load-use hazard detection for the 5-stage MIPS datapath.
- Captures the fetched instruction and PC+4, then splits the held instruction into decode fields.
- imm16 output feeds the decode-stage sign-extension unit directly. Stall output freezes PC and inserts an ID/EX bubble.
- Also keeps a saturating count of stall cycles for performance reporting.

Parameters:
- NOP_WORD, 32'h00000000, instruction word loaded on flush/reset (sll $0,$0,0).
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instr_in  in  32  instruction from instruction memory.
- PCPlus4_in  in  32  PC+4 from fetch.
- Flush  in  1  branch/jump taken in a later stage; squash the instruction being fetched.
- Hold  in  1  external freeze (e.g. memory not ready).
- IDEX_MemRead  in  1  instruction now in EX is a load.
- IDEX_Rt  in  5  destination register of that load.
- Instr_out  out  32  held instruction.
- PCPlus4_out  out  32  held PC+4.
- Valid_out  out  1  held instruction is real (not a bubble).
- Opcode  out  6  Instr_out[31:26].
- Rs  out  5  Instr_out[25:21].
- Rt  out  5  Instr_out[20:16].
- Rd  out  5  Instr_out[15:11].
- Shamt  out  5  Instr_out[10:6].
- Funct  out  6  Instr_out[5:0].
- Imm16  out  16  Instr_out[15:0], to sign extension.
- Stall  out  1  load-use hazard; PCWrite disable, ID/EX bubble select.
- StallCount  out  CNT_WIDTH  saturating count of cycles with Stall or Hold high.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high.
- Reset values: Instr_out=NOP_WORD, PCPlus4_out=0, Valid_out=0, StallCount=0. Stall then evaluates to 0.
- Field outputs are pure combinational slices of Instr_out; zero added latency.
- Register update priority per rising edge: Reset > Flush > (Stall | Hold) > load.
  - Flush: Instr_out<=NOP_WORD, PCPlus4_out<=PCPlus4_in, Valid_out<=0. Flush wins over a simultaneous Stall or Hold.
  - Stall or Hold (no Flush): all registers keep their values.
  - Load: Instr_out<=Instr_in, PCPlus4_out<=PCPlus4_in, Valid_out<=1.
- uses_rt is true when the held instruction reads Rt: Opcode is 0x00 (R-type), 0x04/0x05 (beq/bne), or 0x28/0x29/0x2B (sb/sh/sw).
- Stall (combinational) = Valid_out & IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == Rs) | (uses_rt & IDEX_Rt == Rt)).
- A load-use hazard yields exactly one stall cycle: next cycle ID/EX holds the bubble (IDEX_MemRead=0), so Stall drops with no internal state.
- Stall is not gated by Hold; both may be high together.
- StallCount: increments by 1 on an edge where (Stall | Hold) is high and Reset is low. Saturates at all-ones, no wrap. Counts Flush-coincident stall cycles too.
- Reset mid-stall: the next edge clears everything and Stall is 0 in the following cycle.

Decomposition:
- Shared package/header holds:
  - opcode constants: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SB=6'h28, OP_SH=6'h29, OP_SW=6'h2B, OP_LW=6'h23;
  - NOP_WORD default;
  - field bit positions.
- One sub-module, hazard_detect: combinational Stall from Valid_out, Opcode, Rs, Rt, IDEX_MemRead, IDEX_Rt.
- The top level holds the registers and StallCount.

Test Plan:
- Reset held 2 cycles, then released with Instr_in=32'h8C880004, PCPlus4_in=32'h4 -> during reset Instr_out=0, Valid_out=0, StallCount=0. First edge after release gives Instr_out=32'h8C880004, Rs=4, Rt=8, Imm16=16'h0004, Valid_out=1.
- Load-use: hold add $t2,$t0,$t1 (32'h01095020) with IDEX_MemRead=1, IDEX_Rt=8 -> Stall=1 and registers unchanged for one edge. Then IDEX_MemRead=0 -> Stall=0, the next instruction loads, StallCount=1.
- No false hazard: addi $t1,$t0,5 (32'h21090005), IDEX_MemRead=1, IDEX_Rt=9 -> Stall=0 (uses_rt false). IDEX_Rt=0 with any instruction -> Stall=0.
- Flush during stall: Stall=1 and Flush=1 on the same edge -> Instr_out=0, Valid_out=0. Stall falls to 0 the next cycle. StallCount increments by 1.
- Hold for 3 cycles with Instr_in changing each cycle -> Instr_out and PCPlus4_out frozen, StallCount +3. First edge after Hold drops loads the current Instr_in.
- Saturation with CNT_WIDTH=4: 20 consecutive Hold cycles -> StallCount reaches 4'hF and stays 4'hF.
